// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// rtl/bsg_manycore_link_to_axil_pkg.sv - shared constants for the manycore AXI-Lite bridge
package bsg_manycore_link_to_axil_pkg;

    localparam int host_fifo_width_gp = 128;
    localparam int tx_req_credits_gp  = 4;

    function automatic int bsg_width(input int x);
        return $clog2(x + 1);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_to_axil_tx_buf.sv
// rtl/bsg_manycore_link_to_axil_tx_buf.sv - first-word-fall-through packet buffer with count
module bsg_manycore_link_to_axil_tx_buf
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int width_p = host_fifo_width_gp,
    parameter int els_p   = tx_req_credits_gp,
    localparam int count_width_lp = bsg_width(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [width_p-1:0]        data_i,
    input  logic                      v_i,
    output logic                      full_o,
    output logic [width_p-1:0]        data_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

    logic [width_p-1:0]        mem_r [els_p];
    logic [ptr_width_lp-1:0]   rptr_r, wptr_r;
    logic [count_width_lp-1:0] count_r;
    logic                      full_r, empty_r;

    logic push, pop;
    assign push = v_i & ~full_r;
    assign pop  = yumi_i & ~empty_r;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push) begin
                wptr_r <= (wptr_r == last_ptr_lp) ? '0 : wptr_r + ptr_width_lp'(1);
            end
            if (pop) begin
                rptr_r <= (rptr_r == last_ptr_lp) ? '0 : rptr_r + ptr_width_lp'(1);
            end
            case ({push, pop})
                2'b10: begin
                    count_r <= count_r + count_width_lp'(1);
                    full_r  <= (count_r == count_width_lp'(els_p - 1));
                    empty_r <= 1'b0;
                end
                2'b01: begin
                    count_r <= count_r - count_width_lp'(1);
                    full_r  <= 1'b0;
                    empty_r <= (count_r == count_width_lp'(1));
                end
                default: ;
            endcase
        end
    end

    assign data_o  = mem_r[rptr_r];
    assign v_o     = ~empty_r;
    assign full_o  = full_r;
    assign count_o = count_r;

endmodule

// File: rtl/bsg_manycore_link_to_axil_tx.sv
// rtl/bsg_manycore_link_to_axil_tx.sv - packs AXI-Lite write words into link packets with word credits
module bsg_manycore_link_to_axil_tx
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int axil_data_width_p = 32,
    localparam int ratio_lp         = host_fifo_width_gp / axil_data_width_p,
    localparam int credits_width_lp = bsg_width(ratio_lp * tx_req_credits_gp)
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [axil_data_width_p-1:0]  axil_req_i,
    input  logic                          axil_req_v_i,
    output logic                          axil_req_ready_o,
    output logic [host_fifo_width_gp-1:0] fifo_req_o,
    output logic                          fifo_req_v_o,
    input  logic                          fifo_req_ready_i,
    output logic [credits_width_lp-1:0]   req_credits_o
);

    localparam int cnt_width_lp   = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int count_width_lp = bsg_width(tx_req_credits_gp);
    localparam int occ_width_lp   = credits_width_lp + 1;
    localparam int asm_width_lp   = (ratio_lp - 1) * axil_data_width_p;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(ratio_lp - 1);
    localparam logic [occ_width_lp-1:0] max_occ_lp  = occ_width_lp'(ratio_lp * tx_req_credits_gp);

    logic [cnt_width_lp-1:0]   cnt_r;
    logic [asm_width_lp-1:0]   asm_r;
    logic [count_width_lp-1:0] buf_count;
    logic                      buf_full;
    logic                      accept, last_word;

    assign last_word        = (cnt_r == last_cnt_lp);
    assign axil_req_ready_o = ~last_word | ~buf_full;
    assign accept           = axil_req_v_i & axil_req_ready_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_r <= '0;
        end else if (accept) begin
            cnt_r <= last_word ? '0 : cnt_r + cnt_width_lp'(1);
        end
    end

    // Stale words left by a reset are harmless: cnt_r restarts at 0 and overwrites them in order.
    always_ff @(posedge clk_i) begin
        if (accept && !last_word) begin
            asm_r[cnt_r*axil_data_width_p +: axil_data_width_p] <= axil_req_i;
        end
    end

    bsg_manycore_link_to_axil_tx_buf #(
        .width_p (host_fifo_width_gp),
        .els_p   (tx_req_credits_gp)
    ) tx_buf (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .data_i   ({axil_req_i, asm_r}),
        .v_i      (accept & last_word),
        .full_o   (buf_full),
        .data_o   (fifo_req_o),
        .v_o      (fifo_req_v_o),
        .yumi_i   (fifo_req_ready_i),
        .count_o  (buf_count)
    );

    // Non-final words are taken even when the buffer is full, so occupancy can exceed capacity; clamp at zero.
    logic [occ_width_lp-1:0] occupancy;
    assign occupancy = occ_width_lp'(buf_count) * occ_width_lp'(ratio_lp) + occ_width_lp'(cnt_r);
    assign req_credits_o = (occupancy >= max_occ_lp) ? '0
                                                     : credits_width_lp'(max_occ_lp - occupancy);

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_tx.sv
// tb/tb_bsg_manycore_link_to_axil_tx.sv - scoreboard bench for the AXI-Lite transmit packer
module tb_bsg_manycore_link_to_axil_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  axil_req_i = '0;
    logic         axil_req_v_i = 1'b0;
    logic         axil_req_ready_o;
    logic [127:0] fifo_req_o;
    logic         fifo_req_v_o;
    logic         fifo_req_ready_i = 1'b0;
    logic [4:0]   req_credits_o;

    bsg_manycore_link_to_axil_tx #(.axil_data_width_p(32)) dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .axil_req_i       (axil_req_i),
        .axil_req_v_i     (axil_req_v_i),
        .axil_req_ready_o (axil_req_ready_o),
        .fifo_req_o       (fifo_req_o),
        .fifo_req_v_o     (fifo_req_v_o),
        .fifo_req_ready_i (fifo_req_ready_i),
        .req_credits_o    (req_credits_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    int m_cnt = 0;
    int m_buf = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: tracks buffer/assembly occupancy from observed handshakes and pops the scoreboard.
    always @(negedge clk) begin
        int  occ;
        int  exp_cred;
        logic exp_ready;
        if (!rst_n) begin
            m_cnt = 0;
            m_buf = 0;
            exp_q.delete();
        end else begin
            occ       = m_buf * 4 + m_cnt;
            exp_cred  = (occ >= 16) ? 0 : 16 - occ;
            exp_ready = !(m_cnt == 3 && m_buf == 4);
            chk("credits", 128'(req_credits_o), 128'(exp_cred));
            chk("axil_ready", 128'(axil_req_ready_o), 128'(exp_ready));
            chk("fifo_valid", 128'(fifo_req_v_o), 128'(m_buf != 0));
            if (m_buf != 0 && fifo_req_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet", fifo_req_o, 128'hx);
                end else begin
                    chk("packet", fifo_req_o, exp_q.pop_front());
                end
                m_buf--;
            end
            if (axil_req_v_i && exp_ready) begin
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    m_buf++;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic write_word(input logic [31:0] d);
        int t;
        t = 0;
        axil_req_i   = d;
        axil_req_v_i = 1'b1;
        @(negedge clk);
        while (!axil_req_ready_o && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            checks++;
            failures++;
            $display("FAIL write_timeout actual=stalled required=accept word=%0h", d);
        end
        @(posedge clk);
        #1 axil_req_v_i = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] w0, w1, w2, w3);
        exp_q.push_back({w3, w2, w1, w0});
        write_word(w0);
        write_word(w1);
        write_word(w2);
        write_word(w3);
    endtask

    task automatic drain();
        fifo_req_ready_i = 1'b1;
        repeat (12) @(posedge clk);
        #1 fifo_req_ready_i = 1'b0;
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_credits", 128'(req_credits_o), 128'd16);
        chk("rst_valid", 128'(fifo_req_v_o), 128'd0);
        chk("rst_ready", 128'(axil_req_ready_o), 128'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    bit rdone;

    initial begin
        logic [31:0] w[4];

        pulse_reset();

        // Single packet, no consumer
        send_packet(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        @(negedge clk);
        chk("single_data", fifo_req_o, 128'h44444444_33333333_22222222_11111111);
        chk("single_credits", 128'(req_credits_o), 128'd12);
        @(posedge clk); #1;
        drain();

        // Full stall
        for (int p = 0; p < 4; p++)
            send_packet(32'hA000_0000 + 32'(p*4), 32'hA000_0001 + 32'(p*4),
                        32'hA000_0002 + 32'(p*4), 32'hA000_0003 + 32'(p*4));
        @(negedge clk);
        chk("full_credits", 128'(req_credits_o), 128'd0);
        @(posedge clk); #1;
        exp_q.push_back({32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000});
        write_word(32'hB0000000);
        write_word(32'hB0000001);
        write_word(32'hB0000002);
        fork
            write_word(32'hB0000003);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("stall_ready", 128'(axil_req_ready_o), 128'd0);
                @(posedge clk); #1 fifo_req_ready_i = 1'b1;
                @(posedge clk); #1 fifo_req_ready_i = 1'b0;
            end
        join
        drain();

        // Concurrent push and pop with two packets buffered
        send_packet(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        send_packet(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        exp_q.push_back({32'hE3, 32'hE2, 32'hE1, 32'hE0});
        write_word(32'hE0);
        write_word(32'hE1);
        write_word(32'hE2);
        fork
            write_word(32'hE3);
            begin
                fifo_req_ready_i = 1'b1;
                @(posedge clk); #1 fifo_req_ready_i = 1'b0;
            end
        join
        @(negedge clk);
        chk("concurrent_credits", 128'(req_credits_o), 128'd8);
        @(posedge clk); #1;
        drain();

        // Reset mid-assembly
        write_word(32'hDEAD0000);
        write_word(32'hDEAD0001);
        pulse_reset();
        send_packet(32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hF0F0F0F0);
        drain();

        // Random traffic on both sides
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    w[i % 4] = $urandom;
                    if (i % 4 == 3) exp_q.push_back({w[3], w[2], w[1], w[0]});
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk); #1;
                    end
                    write_word(w[i % 4]);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    fifo_req_ready_i = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        fifo_req_ready_i = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
